// File: rtl/m_dmem_dump_pkg.sv
// ---------------------------------------------------------------------------
// m_dmem_dump_pkg
// Shared definitions for the data-memory dump reader:
//   - dump_state_t   : top-level sequencer states
//   - UART frame constants (10 bits per 8N1 frame, 4 bytes per word)
//   - default bit period for a 50 MHz clock at 115200 baud
//   - word_byte()    : selects a byte of a word, index 0 = most significant
// ---------------------------------------------------------------------------
package m_dmem_dump_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD1  = 3'd1,
    S_RD2  = 3'd2,
    S_SEND = 3'd3,
    S_DONE = 3'd4
  } dump_state_t;

  localparam int BITS_PER_FRAME       = 10;
  localparam int BYTES_PER_WORD       = 4;
  localparam int DEFAULT_CLKS_PER_BIT = 434;

  localparam int BIT_CNT_W  = $clog2(BITS_PER_FRAME);
  localparam int BYTE_IDX_W = $clog2(BYTES_PER_WORD);

  localparam logic [BYTE_IDX_W-1:0] LAST_BYTE = BYTE_IDX_W'(BYTES_PER_WORD - 1);

  // Bytes leave the word most-significant first, so index 0 is [31:24].
  function automatic logic [7:0] word_byte(input logic [31:0]           word,
                                           input logic [BYTE_IDX_W-1:0] idx);
    logic [7:0] sel;
    case (idx)
      2'd0:    sel = word[31:24];
      2'd1:    sel = word[23:16];
      2'd2:    sel = word[15:8];
      default: sel = word[7:0];
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/m_dmem_dump_uart_tx.sv
// ---------------------------------------------------------------------------
// m_uart_tx
// 8N1 byte transmitter with a valid/ready handshake.
//   w_clk    : clock, rising edge
//   w_rst    : synchronous active-high reset (line returns high next cycle)
//   w_valid  : byte offered on w_data
//   w_data   : byte to send, LSB first
//   r_ready  : high when a byte offered now will be accepted
//   r_txd    : serial line, idle high
// A byte accepted while idle puts its start bit on the line in the next
// cycle. r_ready is also high in the last cycle of a stop bit, so a byte
// offered then follows with no idle gap.
// ---------------------------------------------------------------------------
module m_uart_tx
  import m_dmem_dump_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       w_clk,
  input  logic       w_rst,
  input  logic       w_valid,
  input  logic [7:0] w_data,
  output logic       r_ready,
  output logic       r_txd
);

  localparam int TIMER_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TIMER_W-1:0]   TIMER_LAST = TIMER_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_CNT_W-1:0] BIT_LAST   = BIT_CNT_W'(BITS_PER_FRAME - 1);
  // Bit slot whose end hands over to the stop bit (after data bit 7).
  localparam logic [BIT_CNT_W-1:0] BIT_D7     = BIT_CNT_W'(BITS_PER_FRAME - 2);

  logic                 active_reg;
  logic [TIMER_W-1:0]   timer_reg;
  logic [BIT_CNT_W-1:0] bit_cnt_reg;   // 0 = start, 1..8 = data, 9 = stop
  logic [7:0]           shift_reg;

  logic bit_end;
  logic frame_end;
  logic accept;

  assign bit_end   = active_reg && (timer_reg == TIMER_LAST);
  assign frame_end = bit_end && (bit_cnt_reg == BIT_LAST);
  assign r_ready   = !active_reg || frame_end;
  assign accept    = w_valid && r_ready;

  always_ff @(posedge w_clk) begin
    if (w_rst) begin
      active_reg  <= 1'b0;
      timer_reg   <= '0;
      bit_cnt_reg <= '0;
      shift_reg   <= '0;
      r_txd       <= 1'b1;
    end else if (accept) begin
      // New frame: start bit goes out immediately.
      active_reg  <= 1'b1;
      timer_reg   <= '0;
      bit_cnt_reg <= '0;
      shift_reg   <= w_data;
      r_txd       <= 1'b0;
    end else if (active_reg) begin
      if (bit_end) begin
        timer_reg <= '0;
        if (bit_cnt_reg == BIT_LAST) begin
          active_reg <= 1'b0;
          r_txd      <= 1'b1;
        end else begin
          bit_cnt_reg <= bit_cnt_reg + 1'b1;
          if (bit_cnt_reg == BIT_D7) begin
            r_txd <= 1'b1;                  // stop bit
          end else begin
            r_txd     <= shift_reg[0];      // next data bit, LSB first
            shift_reg <= {1'b0, shift_reg[7:1]};
          end
        end
      end else begin
        timer_reg <= timer_reg + 1'b1;
      end
    end
  end

endmodule

// File: rtl/m_dmem_dump.sv
// ---------------------------------------------------------------------------
// m_dmem_dump
// Post-run reader for the processor's data memory. On an accepted start it
// reads N_WORDS consecutive words from a registered-output RAM port and
// streams each word as four 8N1 bytes, most-significant byte first.
//   w_clk    : clock, rising edge
//   w_rst    : synchronous active-high reset, aborts any frame in flight
//   w_start  : level request, sampled only while idle and not yet done
//   w_base   : first word address, captured at start acceptance
//   r_addr   : RAM word address (wraps modulo 2^ADDR_W)
//   r_re     : one-cycle pulse when r_addr carries a new address
//   w_rdata  : RAM read data, valid two cycles after r_addr changes
//   r_txd    : UART serial output, idle high
//   r_busy   : high from start acceptance until the last stop bit ends
//   r_done   : sticky completion flag, cleared only by reset
// ---------------------------------------------------------------------------
module m_dmem_dump
  import m_dmem_dump_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int N_WORDS      = 16,
  parameter int ADDR_W       = 12
) (
  input  logic              w_clk,
  input  logic              w_rst,
  input  logic              w_start,
  input  logic [ADDR_W-1:0] w_base,
  output logic [ADDR_W-1:0] r_addr,
  output logic              r_re,
  input  logic [31:0]       w_rdata,
  output logic              r_txd,
  output logic              r_busy,
  output logic              r_done
);

  localparam int IDX_W = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_WORDS - 1);

  dump_state_t           state_reg;
  dump_state_t           state_next;
  logic [31:0]           word_reg;
  logic [BYTE_IDX_W-1:0] byte_idx_reg;   // byte currently on the line
  logic [IDX_W-1:0]      idx_reg;        // word currently being dumped

  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;

  logic start_ok;
  logic word_end;

  assign start_ok = w_start && !r_done;
  // Last cycle of the fourth stop bit of the current word.
  assign word_end = tx_ready && (byte_idx_reg == LAST_BYTE);

  // -------------------------------------------------------------------------
  // Next state and transmitter feed
  // -------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    tx_valid   = 1'b0;
    tx_data    = 8'h00;
    case (state_reg)
      S_IDLE: begin
        if (start_ok) state_next = S_RD1;
      end
      S_RD1: begin
        state_next = S_RD2;
      end
      S_RD2: begin
        // The transmitter is idle here, so the first byte is taken straight
        // from the RAM output and its start bit appears on the next cycle.
        tx_valid   = 1'b1;
        tx_data    = w_rdata[31:24];
        state_next = S_SEND;
      end
      S_SEND: begin
        if (tx_ready) begin
          if (byte_idx_reg != LAST_BYTE) begin
            // Offered in the last stop-bit cycle: zero gap between bytes.
            tx_valid = 1'b1;
            tx_data  = word_byte(word_reg, BYTE_IDX_W'(byte_idx_reg + 1'b1));
          end else if (idx_reg == LAST_IDX) begin
            state_next = S_DONE;
          end else begin
            state_next = S_RD1;
          end
        end
      end
      S_DONE: begin
        state_next = S_DONE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Sequencer registers
  // -------------------------------------------------------------------------
  always_ff @(posedge w_clk) begin
    if (w_rst) begin
      state_reg    <= S_IDLE;
      r_addr       <= '0;
      r_re         <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      idx_reg      <= '0;
      word_reg     <= '0;
      byte_idx_reg <= '0;
    end else begin
      state_reg <= state_next;
      r_re      <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (start_ok) begin
            r_addr  <= w_base;
            idx_reg <= '0;
            r_re    <= 1'b1;
            r_busy  <= 1'b1;
          end
        end
        S_RD2: begin
          word_reg     <= w_rdata;
          byte_idx_reg <= '0;
        end
        S_SEND: begin
          if (tx_ready) begin
            if (!word_end) begin
              byte_idx_reg <= byte_idx_reg + 1'b1;
            end else if (idx_reg == LAST_IDX) begin
              r_busy <= 1'b0;
              r_done <= 1'b1;
            end else begin
              // Next word: the two cycles in RD1/RD2 leave the line idle.
              idx_reg <= idx_reg + 1'b1;
              r_addr  <= r_addr + 1'b1;
              r_re    <= 1'b1;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Serial transmitter
  // -------------------------------------------------------------------------
  m_uart_tx #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_uart_tx (
    .w_clk   (w_clk),
    .w_rst   (w_rst),
    .w_valid (tx_valid),
    .w_data  (tx_data),
    .r_ready (tx_ready),
    .r_txd   (r_txd)
  );

endmodule

// File: tb/tb_m_dmem_dump.sv
// ---------------------------------------------------------------------------
// tb_m_dmem_dump
// Two instances share one clock and reset: u_dut_a dumps one word per run,
// u_dut_b dumps two. Each has its own registered-output RAM. The expected
// serial waveform of a word is built from the frame rules (start 0, eight
// data bits LSB first, stop 1, each bit CLKS_PER_BIT cycles, MSB byte
// first) and compared against the line sampled every cycle.
// ---------------------------------------------------------------------------
module tb_m_dmem_dump;

  localparam int C  = 4;
  localparam int AW = 12;
  localparam int WAVE_LEN = 40 * C;

  logic          clk = 1'b0;
  logic          rst;
  logic          start [2];
  logic [AW-1:0] base  [2];
  logic [AW-1:0] addr  [2];
  logic          re    [2];
  logic [31:0]   rdata [2];
  logic          txd   [2];
  logic          busy  [2];
  logic          done  [2];

  logic [31:0]   mem [2][4096];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  // Registered-output RAMs: data valid the second cycle after the address.
  always @(posedge clk) begin
    rdata[0] <= mem[0][addr[0]];
    rdata[1] <= mem[1][addr[1]];
  end

  m_dmem_dump #(.CLKS_PER_BIT(C), .N_WORDS(1), .ADDR_W(AW)) u_dut_a (
    .w_clk(clk), .w_rst(rst), .w_start(start[0]), .w_base(base[0]),
    .r_addr(addr[0]), .r_re(re[0]), .w_rdata(rdata[0]),
    .r_txd(txd[0]), .r_busy(busy[0]), .r_done(done[0])
  );

  m_dmem_dump #(.CLKS_PER_BIT(C), .N_WORDS(2), .ADDR_W(AW)) u_dut_b (
    .w_clk(clk), .w_rst(rst), .w_start(start[1]), .w_base(base[1]),
    .r_addr(addr[1]), .r_re(re[1]), .w_rdata(rdata[1]),
    .r_txd(txd[1]), .r_busy(busy[1]), .r_done(done[1])
  );

  task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Line waveform of one word, index 0 = first cycle of the first start bit.
  function automatic logic [159:0] expected_wave(input logic [31:0] word);
    logic [159:0] w;
    logic [31:0]  tmp;
    logic [7:0]   by;
    logic [9:0]   frame;
    int           p;
    w   = '0;
    p   = 0;
    tmp = word;
    for (int k = 0; k < 4; k++) begin
      by    = tmp[31:24];
      tmp   = tmp << 8;
      frame = {1'b1, by, 1'b0};
      for (int j = 0; j < 10; j++)
        for (int r = 0; r < C; r++) begin
          w[p] = frame[j];
          p++;
        end
    end
    return w;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Start a dump on instance d from address b and check the whole run.
  task automatic run_dump(input int d, input logic [AW-1:0] b, input bit chk_bits);
    int            nw;
    logic [159:0]  obs;
    logic [AW-1:0] a;
    logic          done_pre;
    logic [1:0]    gap;
    int            last_t;
    int            bad;
    nw = (d == 0) ? 1 : 2;
    @(negedge clk);
    base[d]  = b;
    start[d] = 1'b1;
    @(negedge clk);                       // cycle t+1
    start[d] = 1'b0;
    check("addr_t1", 160'(addr[d]), 160'(b));
    check("re_t1",   160'(re[d]),   160'(1'b1));
    check("busy_t1", 160'(busy[d]), 160'(1'b1));
    @(negedge clk);                       // cycle t+2
    check("re_t2_txd_t2", 160'({re[d], txd[d]}), 160'(2'b01));
    for (int w = 0; w < nw; w++) begin
      a = b + AW'(w);
      done_pre = 1'b0;
      for (int i = 0; i < WAVE_LEN; i++) begin
        @(negedge clk);
        obs[i] = txd[d];
        if (i == WAVE_LEN - 1) done_pre = done[d];
      end
      check($sformatf("wave_d%0d_w%0d", d, w), obs, expected_wave(mem[d][a]));
      if (chk_bits && w == 0) begin
        // Every line transition lands on a bit-period boundary.
        bad    = 0;
        last_t = 0;
        for (int i = 1; i < WAVE_LEN; i++)
          if (obs[i] !== obs[i-1]) begin
            if ((i - last_t) % C != 0) bad++;
            last_t = i;
          end
        check("bit_intervals", 160'(bad), 160'(0));
        check("frame_bounds",
              160'({obs[0], obs[40], obs[80], obs[120], obs[39], obs[79], obs[119], obs[159]}),
              160'(8'b0000_1111));
      end
      if (w < nw - 1) begin
        @(negedge clk);
        gap[0] = txd[d];
        check("next_addr", 160'({re[d], addr[d]}), 160'({1'b1, AW'(a + 1'b1)}));
        @(negedge clk);
        gap[1] = txd[d];
        check("word_gap", 160'(gap), 160'(2'b11));
      end
    end
    check("done_not_early", 160'(done_pre), 160'(1'b0));
    @(negedge clk);
    check("done_busy_end", 160'({done[d], busy[d], txd[d]}), 160'(3'b101));
  endtask

  initial begin
    logic [AW-1:0] b;
    int            bad;
    int            d;
    for (int i = 0; i < 4096; i++) begin
      mem[0][i] = 32'h0;
      mem[1][i] = 32'h0;
    end
    rst      = 1'b1;
    start[0] = 1'b1;
    start[1] = 1'b1;
    base[0]  = 12'h00A;
    base[1]  = 12'h00B;

    // Reset with start held: nothing leaves either instance.
    bad = 0;
    repeat (4) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++)
        if (txd[k] !== 1'b1 || busy[k] !== 1'b0 || done[k] !== 1'b0 ||
            re[k] !== 1'b0 || addr[k] !== '0) bad++;
    end
    check("reset_state", 160'(bad), 160'(0));
    start[0] = 1'b0;
    start[1] = 1'b0;
    rst      = 1'b0;
    @(negedge clk);
    check("idle_after_reset", 160'({busy[0], busy[1], txd[0], txd[1]}), 160'(4'b0011));

    // Single word 0x12345678 at address 5.
    mem[0][5] = 32'h1234_5678;
    run_dump(0, 12'd5, 1'b1);

    // Done is sticky and further starts are ignored.
    bad = 0;
    repeat (24) begin
      @(negedge clk);
      start[0] = 1'($urandom);
      base[0]  = AW'($urandom);
      if (re[0] !== 1'b0 || txd[0] !== 1'b1 || done[0] !== 1'b1 || busy[0] !== 1'b0) bad++;
    end
    start[0] = 1'b0;
    check("sticky_done", 160'(bad), 160'(0));

    // Two words with address wrap.
    mem[1][4095] = 32'h0000_00FF;
    mem[1][0]    = 32'h8000_0001;
    run_dump(1, 12'd4095, 1'b1);

    // Randomised runs on both instances.
    for (int r = 0; r < 4; r++) begin
      d = r % 2;
      b = AW'($urandom_range(0, 4095));
      mem[d][b]          = $urandom;
      mem[d][AW'(b + 1)] = $urandom;
      do_reset();
      run_dump(d, b, 1'b0);
    end

    // Reset in the middle of the second byte, then a full restart.
    do_reset();
    mem[1][12'h123] = $urandom;
    mem[1][12'h124] = $urandom;
    @(negedge clk);
    base[1]  = 12'h123;
    start[1] = 1'b1;
    @(negedge clk);
    start[1] = 1'b0;
    repeat (2 + 10 * C + 6) @(negedge clk);
    check("in_byte2_busy", 160'(busy[1]), 160'(1'b1));
    rst = 1'b1;
    @(negedge clk);
    check("abort_state", 160'({txd[1], busy[1], done[1], re[1], addr[1]}),
          160'({1'b1, 1'b0, 1'b0, 1'b0, 12'h000}));
    rst = 1'b0;
    run_dump(1, 12'h123, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
